// File: rtl/step_rate_monitor.sv
// Pedometer activity monitor: counts synchronised step pulses per second, tracks
// last/peak rate and a saturating lifetime total, and counts active seconds in a fixed window.
module step_rate_monitor #(
  parameter int THRESH      = 32,
  parameter int WINDOW_SECS = 9,
  parameter int STEP_W      = 7,
  parameter int SEC_W       = 4,
  parameter int TOTAL_W     = 21
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               steps,
  input  logic               sec_tick,
  input  logic               clear,
  output logic [SEC_W-1:0]   secs_over,
  output logic               window_done,
  output logic [STEP_W-1:0]  rate_last,
  output logic [STEP_W-1:0]  rate_max,
  output logic [TOTAL_W-1:0] total_steps
);

  typedef enum logic [0:0] {
    COUNTING = 1'b0,
    DONE     = 1'b1
  } state_e;

  localparam logic [STEP_W-1:0]  STEP_MAX  = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0]  STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};
  localparam logic [TOTAL_W-1:0] TOTAL_ONE = {{(TOTAL_W-1){1'b0}}, 1'b1};
  localparam logic [SEC_W-1:0]   SEC_ONE   = {{(SEC_W-1){1'b0}}, 1'b1};
  localparam logic [SEC_W-1:0]   WIN_LAST  = SEC_W'(WINDOW_SECS);
  // Widened by one bit so a threshold beyond the counter range can never be met.
  localparam logic [STEP_W:0]    THRESH_X  = (THRESH > (2**STEP_W) - 1) ? {1'b1, {STEP_W{1'b0}}}
                                                                        : (STEP_W+1)'(THRESH);

  logic rst_meta_q, rst_sync_q;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [SEC_W-1:0]   sec_idx_q, sec_idx_d;
  logic [SEC_W-1:0]   secs_over_q, secs_over_d;
  logic               window_done_q, window_done_d;
  logic [STEP_W-1:0]  rate_last_q, rate_last_d;
  logic [STEP_W-1:0]  rate_max_q, rate_max_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  state_e             state_q, state_d;

  logic               step_pulse_s;
  logic [STEP_W-1:0]  step_cnt_inc_s;
  logic [STEP_W-1:0]  close_cnt_s;
  logic               over_s;

  // Reset synchroniser: asserts immediately, releases two edges after reset rises.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Step edge, saturating increment and closing count shared by the next-state logic.
  always_comb begin
    step_pulse_s   = sync2_q & ~prev_q;
    step_cnt_inc_s = (step_cnt_q == STEP_MAX) ? step_cnt_q : step_cnt_q + STEP_ONE;
    close_cnt_s    = step_pulse_s ? step_cnt_inc_s : step_cnt_q;
    over_s         = ({1'b0, close_cnt_s} >= THRESH_X);
  end

  // Next-state logic: clear dominates, then step accounting and second closing.
  always_comb begin
    sync1_d       = steps;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    step_cnt_d    = step_cnt_q;
    sec_idx_d     = sec_idx_q;
    secs_over_d   = secs_over_q;
    rate_last_d   = rate_last_q;
    rate_max_d    = rate_max_q;
    total_d       = total_q;
    state_d       = state_q;
    window_done_d = window_done_q;

    if (clear) begin
      sync1_d       = 1'b0;
      sync2_d       = 1'b0;
      prev_d        = 1'b0;
      step_cnt_d    = '0;
      sec_idx_d     = '0;
      secs_over_d   = '0;
      rate_last_d   = '0;
      rate_max_d    = '0;
      total_d       = '0;
      state_d       = COUNTING;
      window_done_d = 1'b0;
    end else begin
      if (step_pulse_s && (total_q != TOTAL_MAX)) begin
        total_d = total_q + TOTAL_ONE;
      end else begin
        total_d = total_q;
      end

      if (sec_tick) begin
        // A step landing with the tick belongs to the second being closed.
        rate_last_d = close_cnt_s;
        rate_max_d  = (close_cnt_s > rate_max_q) ? close_cnt_s : rate_max_q;
        step_cnt_d  = '0;
        case (state_q)
          COUNTING: begin
            secs_over_d = over_s ? secs_over_q + SEC_ONE : secs_over_q;
            sec_idx_d   = sec_idx_q + SEC_ONE;
            state_d     = (sec_idx_d == WIN_LAST) ? DONE : COUNTING;
          end
          DONE: begin
            secs_over_d = secs_over_q;
            sec_idx_d   = sec_idx_q;
            state_d     = DONE;
          end
          default: begin
            state_d = COUNTING;
          end
        endcase
      end else if (step_pulse_s) begin
        step_cnt_d = step_cnt_inc_s;
      end else begin
        step_cnt_d = step_cnt_q;
      end

      window_done_d = (state_d == DONE);
    end
  end

  // State registers, held at zero while the synchronised reset is low.
  always_ff @(posedge CLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      step_cnt_q    <= '0;
      sec_idx_q     <= '0;
      secs_over_q   <= '0;
      window_done_q <= 1'b0;
      rate_last_q   <= '0;
      rate_max_q    <= '0;
      total_q       <= '0;
      state_q       <= COUNTING;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      step_cnt_q    <= step_cnt_d;
      sec_idx_q     <= sec_idx_d;
      secs_over_q   <= secs_over_d;
      window_done_q <= window_done_d;
      rate_last_q   <= rate_last_d;
      rate_max_q    <= rate_max_d;
      total_q       <= total_d;
      state_q       <= state_d;
    end
  end

  assign secs_over   = secs_over_q;
  assign window_done = window_done_q;
  assign rate_last   = rate_last_q;
  assign rate_max    = rate_max_q;
  assign total_steps = total_q;

endmodule

// File: tb/tb_step_rate_monitor.sv
// Scoreboard bench for step_rate_monitor: a per-second behavioural model pushes expected
// outputs when each second is closed; they are popped and compared after the tick edge.
module tb_step_rate_monitor;

  localparam int THRESH      = 32;
  localparam int WINDOW_SECS = 9;
  localparam int STEP_W      = 7;
  localparam int SEC_W       = 4;
  localparam int TOTAL_W     = 21;
  localparam int STEP_MAX    = (1 << STEP_W) - 1;
  localparam int TOTAL_MAX   = (1 << TOTAL_W) - 1;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  logic steps = 1'b0;
  logic sec_tick = 1'b0;
  logic clear = 1'b0;
  logic [SEC_W-1:0]   secs_over;
  logic               window_done;
  logic [STEP_W-1:0]  rate_last;
  logic [STEP_W-1:0]  rate_max;
  logic [TOTAL_W-1:0] total_steps;

  step_rate_monitor #(
    .THRESH(THRESH), .WINDOW_SECS(WINDOW_SECS), .STEP_W(STEP_W),
    .SEC_W(SEC_W), .TOTAL_W(TOTAL_W)
  ) dut (
    .CLK(CLK), .reset(reset), .steps(steps), .sec_tick(sec_tick), .clear(clear),
    .secs_over(secs_over), .window_done(window_done), .rate_last(rate_last),
    .rate_max(rate_max), .total_steps(total_steps)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int rl;
    int rm;
    int so;
    int wd;
    int ts;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt, m_total, m_last, m_max, m_over, m_idx, m_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_total = 0; m_last = 0; m_max = 0; m_over = 0; m_idx = 0; m_done = 0;
  endtask

  task automatic model_step();
    if (m_cnt < STEP_MAX) m_cnt++;
    if (m_total < TOTAL_MAX) m_total++;
  endtask

  task automatic model_close();
    int c;
    c = m_cnt;
    m_last = c;
    if (c > m_max) m_max = c;
    m_cnt = 0;
    if (m_idx < WINDOW_SECS) begin
      if (c >= THRESH) m_over++;
      m_idx++;
    end
    m_done = (m_idx == WINDOW_SECS) ? 1 : 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e = '{m_last, m_max, m_over, m_done, m_total};
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, ".rate_last"},   32'(rate_last),   32'(e.rl));
      check_val({tag, ".rate_max"},    32'(rate_max),    32'(e.rm));
      check_val({tag, ".secs_over"},   32'(secs_over),   32'(e.so));
      check_val({tag, ".window_done"}, 32'(window_done), 32'(e.wd));
      check_val({tag, ".total_steps"}, 32'(total_steps), 32'(e.ts));
    end
  endtask

  task automatic one_step();
    steps = 1'b1; tick(); tick();
    steps = 1'b0; tick(); tick();
    model_step();
  endtask

  task automatic close_second(input string tag);
    repeat (3) tick();
    sec_tick = 1'b1;
    model_close();
    push_exp();
    tick();
    sec_tick = 1'b0;
    compare_out(tag);
  endtask

  task automatic run_second(input int n, input string tag);
    repeat (n) one_step();
    close_second(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    model_reset();
    push_exp();
    tick();
    clear = 1'b0;
    compare_out("clear");
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    push_exp();
    compare_out("reset");
    reset = 1'b1;
    repeat (3) tick();

    // 40 steps per second: window fills on the 9th tick, the 10th second is not counted.
    for (int i = 0; i < 10; i++) run_second(40, $sformatf("t1_s%0d", i + 1));
    check_val("t1_secs_over", 32'(secs_over), 32'd9);
    check_val("t1_total", 32'(total_steps), 32'd400);
    check_val("t1_done", 32'(window_done), 32'd1);
    do_clear();

    // Alternating just-below / at threshold.
    for (int i = 0; i < 9; i++) run_second((i % 2 == 0) ? 31 : 32, $sformatf("t2_s%0d", i + 1));
    check_val("t2_secs_over", 32'(secs_over), 32'd4);
    check_val("t2_rate_last", 32'(rate_last), 32'd31);
    check_val("t2_rate_max", 32'(rate_max), 32'd32);
    do_clear();

    // 32nd step's pulse coincides with sec_tick and belongs to the closing second.
    repeat (31) one_step();
    repeat (3) tick();
    steps = 1'b1;
    tick(); tick();
    sec_tick = 1'b1;
    model_step();
    model_close();
    push_exp();
    tick();
    sec_tick = 1'b0;
    compare_out("t3_aligned");
    check_val("t3_rate_last", 32'(rate_last), 32'd32);
    check_val("t3_secs_over", 32'(secs_over), 32'd1);
    steps = 1'b0;
    tick(); tick();
    run_second(0, "t3_next");
    check_val("t3_cnt_zeroed", 32'(rate_last), 32'd0);
    do_clear();

    // Per-second counter saturates, lifetime total does not.
    run_second(200, "t4");
    check_val("t4_rate_last", 32'(rate_last), 32'd127);
    check_val("t4_rate_max", 32'(rate_max), 32'd127);
    check_val("t4_total", 32'(total_steps), 32'd200);
    do_clear();

    // Asynchronous reset in the middle of second 5.
    for (int i = 0; i < 4; i++) run_second(35, $sformatf("t5_pre%0d", i + 1));
    repeat (10) one_step();
    reset = 1'b0;
    #2;
    model_reset();
    push_exp();
    compare_out("t5_async");
    tick();
    reset = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 9; i++) run_second(35, $sformatf("t5_s%0d", i + 1));
    check_val("t5_secs_over", 32'(secs_over), 32'd9);
    check_val("t5_done", 32'(window_done), 32'd1);

    // clear together with sec_tick discards the closing second.
    repeat (10) one_step();
    repeat (3) tick();
    clear = 1'b1;
    sec_tick = 1'b1;
    model_reset();
    push_exp();
    tick();
    clear = 1'b0;
    sec_tick = 1'b0;
    compare_out("t6_clear_tick");
    check_val("t6_rate_last", 32'(rate_last), 32'd0);
    run_second(33, "t6_after");

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
